// File: rtl/demux_frame_nch_pkg.sv
// Shared constants and helpers for the frame demultiplexer family.
// Mode encodings and lane slicing are reused by the mux successor.
package demux_frame_nch_pkg;

    // Pointer advances every cycle
    localparam int DEMUX_SLOT = 0;
    // Pointer advances only on valid beats
    localparam int DEMUX_PACK = 1;

    // Low bit of a lane inside a flattened lane bus
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Width of a pointer covering the given lane count
    function automatic int slot_bits(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// Modulo-CHANNELS slot pointer with realign.
// wrap flags the beat that completes a frame.
module demux_slot_ctr
    import demux_frame_nch_pkg::*;
#(
    parameter int CHANNELS = 2,
    localparam int SW = slot_bits(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          align,
    output logic [SW-1:0] slot,
    output logic          wrap
);

    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    logic [SW-1:0] slot_next;

    // Next pointer; align restarts at 0, or at 1 when its beat is taken
    always_comb begin
        slot_next = slot;
        wrap      = 1'b0;
        if (align) begin
            slot_next = advance ? SW'(1) : '0;
        end else if (advance) begin
            if (slot == LAST) begin
                slot_next = '0;
                wrap      = 1'b1;
            end else begin
                slot_next = slot + SW'(1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else begin
            slot <= slot_next;
        end
    end

endmodule

// File: rtl/demux_frame_nch.sv
// N-channel frame demultiplexer: serial beats into parallel lanes.
// Completed frames appear on all lanes at once with a one-cycle strobe.
module demux_frame_nch
    import demux_frame_nch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 2,
    parameter int PACK = DEMUX_SLOT,
    localparam int SW = slot_bits(CHANNELS)
) (
    input  logic                      clk8f,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      valid_in,
    input  logic                      align,
    output logic [WIDTH*CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0]       valid_out,
    output logic                      frame_strobe,
    output logic [SW-1:0]             slot
);

    localparam bit PACK_MODE = (PACK == DEMUX_PACK);

    logic                accept;
    logic                wrap;
    logic [WIDTH-1:0]    cap_data [CHANNELS];
    logic [CHANNELS-1:0] cap_valid;

    // Pack mode drops invalid beats; slot mode takes every beat
    assign accept = PACK_MODE ? valid_in : 1'b1;

    demux_slot_ctr #(
        .CHANNELS (CHANNELS)
    ) u_slot_ctr (
        .clk     (clk8f),
        .rst_n   (reset),
        .advance (accept),
        .align   (align),
        .slot    (slot),
        .wrap    (wrap)
    );

    genvar s;
    for (s = 0; s < CHANNELS - 1; s++) begin : g_stage
        localparam logic [SW-1:0] IDX = SW'(s);
        localparam logic FIRST = (s == 0);

        logic [WIDTH-1:0] d_q;
        logic             v_q;
        logic             hit;

        assign hit = accept && (align ? FIRST : (slot == IDX));

        // Staging lane: hold the beat aimed at this slot, drop on align
        always_ff @(posedge clk8f or negedge reset) begin
            if (!reset) begin
                d_q <= '0;
                v_q <= 1'b0;
            end else if (hit) begin
                d_q <= data_in;
                v_q <= valid_in;
            end else if (align) begin
                v_q <= 1'b0;
            end
        end

        assign cap_data[s]  = d_q;
        assign cap_valid[s] = v_q;
    end

    // The last lane is fed straight from the completing beat
    assign cap_data[CHANNELS-1]  = data_in;
    assign cap_valid[CHANNELS-1] = valid_in;

    genvar l;
    for (l = 0; l < CHANNELS; l++) begin : g_lane
        localparam int LSB = lane_lsb(l, WIDTH);

        logic [WIDTH-1:0] d_q;
        logic             v_q;

        // Output lane: refresh on frame completion, invalid lanes keep data
        always_ff @(posedge clk8f or negedge reset) begin
            if (!reset) begin
                d_q <= '0;
                v_q <= 1'b0;
            end else if (wrap) begin
                v_q <= cap_valid[l];
                if (cap_valid[l]) begin
                    d_q <= cap_data[l];
                end
            end
        end

        assign data_out[LSB +: WIDTH] = d_q;
        assign valid_out[l]           = v_q;
    end

    // Frame strobe follows the completing beat by one edge
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= wrap;
        end
    end

endmodule

// File: tb/tb_demux_frame_nch.sv
// Self-checking bench for demux_frame_nch in four configurations.
// A beat-counting frame model predicts every output each cycle.
module tb_demux_frame_nch;

    logic        clk8f = 1'b0;
    logic        reset;
    logic [15:0] in_d [4];
    logic        in_v [4];
    logic        in_a [4];

    always #5 clk8f = ~clk8f;

    logic [15:0]  o2_d;
    logic [1:0]   o2_v;
    logic         o2_s;
    logic [0:0]   o2_sl;
    logic [31:0]  o4p_d;
    logic [3:0]   o4p_v;
    logic         o4p_s;
    logic [1:0]   o4p_sl;
    logic [31:0]  o4s_d;
    logic [3:0]   o4s_v;
    logic         o4s_s;
    logic [1:0]   o4s_sl;
    logic [127:0] o8_d;
    logic [7:0]   o8_v;
    logic         o8_s;
    logic [2:0]   o8_sl;

    demux_frame_nch #(.WIDTH(8), .CHANNELS(2), .PACK(0)) u2 (
        .clk8f(clk8f), .reset(reset),
        .data_in(in_d[0][7:0]), .valid_in(in_v[0]), .align(in_a[0]),
        .data_out(o2_d), .valid_out(o2_v),
        .frame_strobe(o2_s), .slot(o2_sl)
    );

    demux_frame_nch #(.WIDTH(8), .CHANNELS(4), .PACK(1)) u4p (
        .clk8f(clk8f), .reset(reset),
        .data_in(in_d[1][7:0]), .valid_in(in_v[1]), .align(in_a[1]),
        .data_out(o4p_d), .valid_out(o4p_v),
        .frame_strobe(o4p_s), .slot(o4p_sl)
    );

    demux_frame_nch #(.WIDTH(8), .CHANNELS(4), .PACK(0)) u4s (
        .clk8f(clk8f), .reset(reset),
        .data_in(in_d[2][7:0]), .valid_in(in_v[2]), .align(in_a[2]),
        .data_out(o4s_d), .valid_out(o4s_v),
        .frame_strobe(o4s_s), .slot(o4s_sl)
    );

    demux_frame_nch #(.WIDTH(16), .CHANNELS(8), .PACK(0)) u8 (
        .clk8f(clk8f), .reset(reset),
        .data_in(in_d[3]), .valid_in(in_v[3]), .align(in_a[3]),
        .data_out(o8_d), .valid_out(o8_v),
        .frame_strobe(o8_s), .slot(o8_sl)
    );

    int checks = 0;
    int failures = 0;

    int ch [4] = '{2, 4, 4, 8};
    int wd [4] = '{8, 8, 8, 16};
    bit pk [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    int          m_cnt [4];
    logic [15:0] m_bd [4][8];
    logic        m_bv [4][8];
    logic [15:0] m_od [4][8];
    logic        m_ov [4][8];
    logic        m_str [4];

    typedef struct packed {
        logic [7:0]  d;
        logic        v;
        logic [15:0] ed;
        logic [1:0]  ev;
        logic        es;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input int id,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h want=%0h", nm, id, act, exp);
        end
    endtask

    task automatic m_reset(input int id);
        m_cnt[id] = 0;
        m_str[id] = 1'b0;
        for (int l = 0; l < 8; l++) begin
            m_od[id][l] = '0;
            m_ov[id][l] = 1'b0;
        end
    endtask

    // Frame model: collect accepted beats, emit a frame on the CH-th one
    task automatic m_step(input int id);
        logic [15:0] d;
        bit          take;
        d = (wd[id] == 16) ? in_d[id] : {8'h00, in_d[id][7:0]};
        take = !pk[id] || in_v[id];
        m_str[id] = 1'b0;
        if (in_a[id]) begin
            m_cnt[id] = 0;
            if (take) begin
                m_bd[id][0] = d;
                m_bv[id][0] = in_v[id];
                m_cnt[id] = 1;
            end
        end else if (take) begin
            m_bd[id][m_cnt[id]] = d;
            m_bv[id][m_cnt[id]] = in_v[id];
            m_cnt[id]++;
            if (m_cnt[id] == ch[id]) begin
                for (int l = 0; l < ch[id]; l++) begin
                    m_ov[id][l] = m_bv[id][l];
                    if (m_bv[id][l]) m_od[id][l] = m_bd[id][l];
                end
                m_str[id] = 1'b1;
                m_cnt[id] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [127:0] ad, ed;
        logic [7:0]   av, ev;
        logic         as;
        logic [2:0]   asl;
        for (int id = 0; id < 4; id++) begin
            case (id)
                0: begin
                    ad = 128'(o2_d); av = 8'(o2_v);
                    as = o2_s; asl = 3'(o2_sl);
                end
                1: begin
                    ad = 128'(o4p_d); av = 8'(o4p_v);
                    as = o4p_s; asl = 3'(o4p_sl);
                end
                2: begin
                    ad = 128'(o4s_d); av = 8'(o4s_v);
                    as = o4s_s; asl = 3'(o4s_sl);
                end
                default: begin
                    ad = o8_d; av = o8_v;
                    as = o8_s; asl = o8_sl;
                end
            endcase
            ed = '0;
            ev = '0;
            for (int l = 0; l < ch[id]; l++) begin
                for (int b = 0; b < wd[id]; b++)
                    ed[l*wd[id]+b] = m_od[id][l][b];
                ev[l] = m_ov[id][l];
            end
            chk("data", id, ad, ed);
            chk("valid", id, 128'(av), 128'(ev));
            chk("strobe", id, 128'(as), 128'(m_str[id]));
            chk("slot", id, 128'(asl), 128'(m_cnt[id]));
        end
    endtask

    task automatic tick();
        @(posedge clk8f);
        for (int id = 0; id < 4; id++) begin
            if (!reset) m_reset(id);
            else m_step(id);
        end
        #1;
        check_all();
    endtask

    task automatic rand_in(input int id);
        in_d[id] = 16'($urandom);
        in_v[id] = 1'($urandom);
        in_a[id] = ($urandom_range(0, 11) == 0);
    endtask

    initial begin
        logic [5:0]   pat;
        logic [127:0] ramp;
        int           nstb;

        tbl[0]  = '{8'h13, 1'b1, 16'h0000, 2'b00, 1'b0};
        tbl[1]  = '{8'hFD, 1'b1, 16'hFD13, 2'b11, 1'b1};
        tbl[2]  = '{8'h13, 1'b1, 16'hFD13, 2'b11, 1'b0};
        tbl[3]  = '{8'hFD, 1'b1, 16'hFD13, 2'b11, 1'b1};
        tbl[4]  = '{8'h14, 1'b1, 16'hFD13, 2'b11, 1'b0};
        tbl[5]  = '{8'hFC, 1'b0, 16'hFD14, 2'b01, 1'b1};
        tbl[6]  = '{8'h15, 1'b1, 16'hFD14, 2'b01, 1'b0};
        tbl[7]  = '{8'hFC, 1'b0, 16'hFD15, 2'b01, 1'b1};
        tbl[8]  = '{8'h16, 1'b0, 16'hFD15, 2'b01, 1'b0};
        tbl[9]  = '{8'h77, 1'b1, 16'h7715, 2'b10, 1'b1};
        tbl[10] = '{8'h01, 1'b0, 16'h7715, 2'b10, 1'b0};
        tbl[11] = '{8'h02, 1'b0, 16'h7715, 2'b00, 1'b1};

        pat  = 6'b101101;
        nstb = 0;

        reset = 1'b0;
        for (int id = 0; id < 4; id++) begin
            in_d[id] = 16'h0011;
            in_v[id] = 1'b1;
            in_a[id] = 1'b0;
            m_reset(id);
        end
        repeat (4) tick();
        chk("rst_data", 0, 128'(o2_d), 128'h0);
        chk("rst_valid", 0, 128'(o2_v), 128'h0);
        chk("rst_strobe", 0, 128'(o2_s), 128'h0);
        reset = 1'b1;

        for (int k = 0; k < 64; k++) begin
            if (k < 12) begin
                in_d[0] = {8'h00, tbl[k].d};
                in_v[0] = tbl[k].v;
                in_a[0] = 1'b0;
            end else begin
                rand_in(0);
            end
            if (k < 6) begin
                in_d[1] = 16'(32'h20 + k);
                in_v[1] = pat[k];
                in_a[1] = 1'b0;
            end else begin
                rand_in(1);
            end
            in_v[2] = 1'b1;
            in_a[2] = 1'b0;
            case (k)
                0: in_d[2] = 16'h30;
                1: in_d[2] = 16'h31;
                2: begin in_d[2] = 16'h1B; in_a[2] = 1'b1; end
                3: in_d[2] = 16'h40;
                4: in_d[2] = 16'h41;
                5: in_d[2] = 16'h42;
                6: in_d[2] = 16'h50;
                7: in_d[2] = 16'h51;
                8: in_d[2] = 16'h52;
                9: begin in_d[2] = 16'h60; in_a[2] = 1'b1; end
                default: rand_in(2);
            endcase
            in_d[3] = 16'(k);
            in_v[3] = 1'b1;
            in_a[3] = 1'b0;

            tick();

            if (k < 12) begin
                chk("tbl_data", 0, 128'(o2_d), 128'(tbl[k].ed));
                chk("tbl_valid", 0, 128'(o2_v), 128'(tbl[k].ev));
                chk("tbl_strobe", 0, 128'(o2_s), 128'(tbl[k].es));
            end
            if (k == 5) begin
                chk("pack_data", 1, 128'(o4p_d), 128'h25232220);
                chk("pack_valid", 1, 128'(o4p_v), 128'hF);
                chk("pack_strobe", 1, 128'(o4p_s), 128'h1);
                chk("align_data", 2, 128'(o4s_d), 128'h4241401B);
                chk("align_strobe", 2, 128'(o4s_s), 128'h1);
            end
            if (k == 2 || k == 9) begin
                chk("align_nostb", 2, 128'(o4s_s), 128'h0);
                chk("align_slot", 2, 128'(o4s_sl), 128'h1);
            end
            if (o8_s) nstb++;
            if (k % 8 == 7) begin
                ramp = '0;
                for (int l = 0; l < 8; l++)
                    ramp = ramp | (128'(k - 7 + l) << (16 * l));
                chk("ramp_data", 3, o8_d, ramp);
                chk("ramp_valid", 3, 128'(o8_v), 128'hFF);
            end
        end
        chk("ramp_strobes", 3, 128'(nstb), 128'd8);

        reset = 1'b0;
        #3;
        for (int id = 0; id < 4; id++) m_reset(id);
        check_all();
        repeat (2) tick();
        reset = 1'b1;

        for (int n = 0; n < 300; n++) begin
            for (int id = 0; id < 4; id++) rand_in(id);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
